result_serializer: RTL and testbench
====================================

# result_serializer

Streams the product matrix out of the result memory over UART. It sits downstream of the matrix multiplier and result memory, and upstream of `uart_tx`. After `start`, it reads each 32-bit result element in address order and splits it into four bytes, most significant byte first. It hands each byte to `uart_tx` through the start/busy handshake, then pulses `done`.

## Interface
- `DATA_W`, 32, result element width; must be a multiple of 8.
- `ADDR_W`, 4, result memory address width.
- `MAX_DIM`, 4, largest supported matrix dimension; `MAX_DIM*MAX_DIM <= 2**ADDR_W`.
- `clk` input 1: the only clock; `top` connects it to the baud clock `bclk`.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin serializing.
- `matrix_size` input 4: dimension n; the block sends n*n elements.
- `result_addr` output ADDR_W: result memory read address.
- `result_data` input DATA_W: read data, valid one cycle after `result_addr`.
- `tx_data` output 8: byte presented to `uart_tx`.
- `tx_start` output 1: one-cycle request to `uart_tx`.
- `tx_busy` input 1: `uart_tx` busy flag.
- `busy` output 1: serialization in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: waiting for `start`.
  - READ: `result_addr` holds the element index.
  - LATCH: capture `result_data` into a shift register; byte index = 0.
  - SEND: assert `tx_start` for one cycle, only when `tx_busy`=0; otherwise hold in SEND.
  - WAIT_HI: wait for `tx_busy`=1.
  - WAIT_LO: wait for `tx_busy`=0.
  - CKSUM: only with the checksum feature; sends the checksum byte.
  - FINISH: pulse `done`, return to IDLE.
- IDLE→READ on `start`; `matrix_size` is sampled at that edge.
- WAIT_LO exit:
  - more bytes left in the word → SEND, shift register rotates 8 bits;
  - last byte of the word, more words left → READ with index+1;
  - last word → CKSUM or FINISH.
- Element count = n*n, where n is the sampled `matrix_size`:
  - n=0 → IDLE→FINISH directly; no bytes sent;
  - n>MAX_DIM → clamped to MAX_DIM.
- `start` outside IDLE is ignored; no queuing.
- `tx_data` always equals the top byte of the shift register. It is stable from the `tx_start` cycle until the matching `tx_busy` falls.
- Byte order:
  - elements: address 0 upward;
  - within an element: bits [31:24] first, [7:0] last.
- Reset:
  - all state clears and the FSM goes to IDLE, including mid-transfer;
  - outputs after reset: `tx_start`=0, `done`=0, `busy`=0, `result_addr`=0, `tx_data`=0x00.
  - A byte already accepted by `uart_tx` completes independently; the serializer does not wait for it.

## Timing
- `start` sampled at edge t:
  - READ during t+1, with `result_addr`=0;
  - LATCH during t+2, capturing `result_data`;
  - SEND during t+3, so first `tx_start` at t+3 at the earliest.
- `tx_start` is high for exactly one cycle per byte. It is never asserted while `tx_busy`=1, and never while in WAIT_HI or WAIT_LO.
- WAIT_HI has no timeout. `uart_tx` is required to raise `busy` within one cycle of `tx_start`.
- Per-byte overhead beyond the UART frame: 2 cycles (SEND to WAIT_HI, WAIT_LO exit). Word fetch adds 2 cycles (READ, LATCH).
- `busy`:
  - 1 from t+1 through the FINISH cycle inclusive;
  - `done`=1 only in FINISH, one cycle after the final `tx_busy` fall.
- For n=0, `done` pulses at t+1 and `busy` is high only in that cycle.
- All outputs are registered.

## Configuration
- `RESULT_SER_CKSUM_EN` defined:
  - after the last data byte, CKSUM sends one extra byte: the XOR of every data byte sent in this run;
  - the checksum is reset at IDLE→READ;
  - for n=0, no checksum byte is sent.
- Undefined: CKSUM state and checksum register are absent; the last word goes straight to FINISH.

## Structure
- Shared package `matrix_pkg` holds:
  - the state enum;
  - `MAX_DIM`, `DATA_W` and `ADDR_W` defaults;
  - a bytes-per-word constant `DATA_W/8`.
- One natural sub-module: `uart_byte_sender`. It owns the SEND/WAIT_HI/WAIT_LO handshake, takes a byte-valid input and returns a byte-done pulse. The serializer FSM owns word and address sequencing.

## Test plan
- n=2, memory = {0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00}, model `uart_tx` busy 10 cycles → 16 bytes 11 22 33 … FF 00 in order, then one `done` pulse, `busy` low next cycle.
- n=0 `start` → no `tx_start`; `done` at t+1.
- n=7 → clamped to 16 elements (64 bytes); `result_addr` never exceeds 15.
- Hold `tx_busy`=1 for 50 cycles before the first byte → serializer waits in SEND with `tx_start`=0, then sends once busy drops; `tx_data` stays stable throughout.
- Second `start` mid-transfer, then `rst` during word 1 byte 2 → the second `start` is ignored; after `rst`, all outputs are at reset values the next cycle, and a fresh `start` resends from address 0.
- With `RESULT_SER_CKSUM_EN`, n=1, element 0x01020304 → bytes 01 02 03 04 04 (0x01^0x02^0x03^0x04 = 0x04), then `done`.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and default sizes for the matrix datapath blocks.
// Used by result_serializer and uart_byte_sender.
package matrix_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_ADDR_W  = 4;
    localparam int unsigned DEF_MAX_DIM = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StSend,
        StWaitHi,
        StWaitLo,
        StCksum,
        StFinish
    } ser_state_e;

    function automatic int unsigned bytes_per_word(int unsigned w);
        return w / 8;
    endfunction

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEF_DATA_W);

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte start/busy handshake towards uart_tx: strobes tx_start once the
// transmitter is free, then tracks its busy pulse and reports completion.
module uart_byte_sender
    import matrix_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic byte_valid_i,
    input  logic tx_busy_i,
    output logic tx_start_o,
    output logic byte_done_o,
    output logic idle_o
);

    ser_state_e state_q;
    logic       tx_start_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (byte_valid_i) begin
                        if (!tx_busy_i) begin
                            tx_start_q <= 1'b1;
                            state_q    <= StWaitHi;
                        end else begin
                            state_q <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        state_q    <= StWaitHi;
                    end
                end
                // First WaitHi cycle carries the tx_start strobe.
                StWaitHi: if (tx_busy_i) state_q <= StWaitLo;
                StWaitLo: if (!tx_busy_i) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign tx_start_o  = tx_start_q;
    assign byte_done_o = (state_q == StWaitLo) && !tx_busy_i;
    assign idle_o      = (state_q == StIdle);

endmodule

// File: rtl/result_serializer.sv
// Streams n*n result words over uart_tx, MSB byte first, then pulses done.
// Define RESULT_SER_CKSUM_EN to append an XOR checksum byte after the data.
module result_serializer
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned MAX_DIM = DEF_MAX_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic [ADDR_W-1:0] result_addr,
    input  logic [DATA_W-1:0] result_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NumBytes = bytes_per_word(DATA_W);
    localparam int unsigned ByteIdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(NumBytes - 1);

    ser_state_e          state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   last_q;
    logic [DATA_W-1:0]   shift_q;
    logic [ByteIdxW-1:0] byte_idx_q;
    logic                busy_q;
    logic                done_q;

    logic [3:0]          dim;
    logic [7:0]          elem_cnt;
    logic [ADDR_W-1:0]   last_idx;
    logic [7:0]          top_byte;
    logic [DATA_W-1:0]   rotated;
    logic                byte_valid;
    logic                byte_done;
    logic                snd_idle;

    always_comb begin
        dim      = (matrix_size > 4'(MAX_DIM)) ? 4'(MAX_DIM) : matrix_size;
        elem_cnt = {4'd0, dim} * {4'd0, dim};
        last_idx = ADDR_W'(elem_cnt - 8'd1);
        top_byte = shift_q[DATA_W-1 -: 8];
        rotated  = (shift_q << 8) | (shift_q >> (DATA_W - 8));
    end

`ifdef RESULT_SER_CKSUM_EN
    logic [7:0]        cksum_q;
    logic [DATA_W-1:0] cksum_word;

    // Checksum byte goes out through the top of the shift register like data.
    always_comb begin
        cksum_word                   = shift_q;
        cksum_word[DATA_W-1 -: 8]    = cksum_q ^ top_byte;
    end
`endif

    // A byte is offered in LATCH and whenever the sender is idle mid-word.
    assign byte_valid = (state_q == StLatch) ||
                        (((state_q == StSend) || (state_q == StCksum)) && snd_idle);

    uart_byte_sender u_sender (
        .clk_i       (clk),
        .rst_i       (rst),
        .byte_valid_i(byte_valid),
        .tx_busy_i   (tx_busy),
        .tx_start_o  (tx_start),
        .byte_done_o (byte_done),
        .idle_o      (snd_idle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef RESULT_SER_CKSUM_EN
            cksum_q    <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q <= '0;
                        last_q <= last_idx;
                        busy_q <= 1'b1;
`ifdef RESULT_SER_CKSUM_EN
                        cksum_q <= 8'h00;
`endif
                        if (dim == 4'd0) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: state_q <= StLatch;
                StLatch: begin
                    shift_q    <= result_data;
                    byte_idx_q <= '0;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (byte_done) begin
`ifdef RESULT_SER_CKSUM_EN
                        cksum_q <= cksum_q ^ top_byte;
`endif
                        if (byte_idx_q != LastByte) begin
                            shift_q    <= rotated;
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end else if (addr_q != last_q) begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= StRead;
                        end else begin
`ifdef RESULT_SER_CKSUM_EN
                            shift_q <= cksum_word;
                            state_q <= StCksum;
`else
                            state_q <= StFinish;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef RESULT_SER_CKSUM_EN
                StCksum: begin
                    if (byte_done) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                    end
                end
`endif
                StFinish: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result_addr = addr_q;
    assign tx_data     = top_byte;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: behavioural memory and uart_tx
// models plus a byte-list reference built directly from the memory contents.
module tb_result_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  matrix_size = 4'd0;
    logic [3:0]  result_addr;
    logic [31:0] result_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        busy;
    logic        done;

    logic [31:0] mem [16];
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];

    int          n_tests = 0;
    int          n_fail  = 0;

    int unsigned busy_len   = 4;
    int unsigned busy_cnt   = 0;
    logic        uart_busy  = 1'b0;
    logic        force_busy = 1'b0;
    logic [7:0]  inflight   = 8'h00;
    int          proto_err  = 0;
    int          stab_err   = 0;
    bit          stab_en    = 1'b1;
    int          done_cnt   = 0;
    int          max_addr   = 0;

    always #5 clk = ~clk;

    result_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .matrix_size(matrix_size),
        .result_addr(result_addr),
        .result_data(result_data),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk) result_data <= mem[result_addr];

    assign tx_busy = uart_busy | force_busy;

    // uart_tx model: accepts a byte on tx_start, then stays busy busy_len cycles.
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (busy && int'(result_addr) > max_addr) max_addr = int'(result_addr);
        if (uart_busy && stab_en && tx_data !== inflight) stab_err++;
        if (tx_start) begin
            if (tx_busy) proto_err++;
            rx_q.push_back(tx_data);
            inflight  <= tx_data;
            uart_busy <= 1'b1;
            busy_cnt  <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt  <= 0;
            uart_busy <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: every element in address order, MSB byte first, optional XOR byte.
    task automatic build_exp(input int n);
        int         dim;
        logic [7:0] x;
        dim = (n > 4) ? 4 : n;
        x   = 8'h00;
        exp_q.delete();
        for (int e = 0; e < dim * dim; e++) begin
            for (int b = 3; b >= 0; b--) begin
                logic [7:0] v;
                v = 8'(mem[e] >> (8 * b));
                exp_q.push_back(v);
                x = x ^ v;
            end
        end
`ifdef RESULT_SER_CKSUM_EN
        if (dim > 0) exp_q.push_back(x);
`endif
    endtask

    task automatic run_job(input int n, input int unsigned blen, input int hold,
                           output int first_start, output int done_cyc);
        int         cyc;
        bit         got_done;
        bit         busy_t1;
        bit         busy_at_done;
        logic [3:0] addr_t1;
        logic [7:0] held;
        int         hold_err;
        int         nb;
        cyc = 0; got_done = 0; busy_t1 = 0; busy_at_done = 0; addr_t1 = 4'hf;
        held = 8'h00; hold_err = 0; first_start = 0; done_cyc = 0;
        build_exp(n);
        rx_q.delete();
        done_cnt = 0;
        max_addr = 0;
        busy_len = blen;
        if (hold > 0) force_busy = 1'b1;
        @(negedge clk);
        matrix_size = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_t1 = busy;
        addr_t1 = result_addr;
        while (!got_done && cyc < 6000) begin
            if (tx_start && first_start == 0) first_start = cyc;
            if (hold > 0 && cyc == 3) held = tx_data;
            if (hold > 0 && cyc > 3 && cyc <= hold && tx_data !== held) hold_err++;
            if (hold > 0 && cyc == hold) force_busy = 1'b0;
            if (done) begin
                got_done     = 1;
                done_cyc     = cyc;
                busy_at_done = busy;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("done_seen", 32'(got_done), 32'd1);
        check_eq("busy_at_t1", 32'(busy_t1), 32'd1);
        check_eq("busy_in_finish", 32'(busy_at_done), 32'd1);
        if (n > 0) check_eq("addr_at_t1", 32'(addr_t1), 32'd0);
        check_eq("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
        nb = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < nb; i++)
            check_eq($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        if (hold > 0) begin
            check_eq("hold_txdata_stable", 32'(hold_err), 32'd0);
            check_eq("hold_txdata_value", 32'(held), 32'(exp_q[0]));
            check_eq("hold_start_late", 32'(first_start > hold), 32'd1);
        end
        @(negedge clk);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        force_busy = 1'b0;
    endtask

    task automatic wait_rx(input int cnt, input string tag);
        int cyc;
        cyc = 0;
        while (rx_q.size() < cnt && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq(tag, 32'(rx_q.size() >= cnt), 32'd1);
    endtask

    initial begin
        int fs;
        int dc;
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_addr", 32'(result_addr), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;

        // Directed 2x2 with a slow transmitter.
        mem[0] = 32'h11223344; mem[1] = 32'h55667788;
        mem[2] = 32'h99AABBCC; mem[3] = 32'hDDEEFF00;
        run_job(2, 10, 0, fs, dc);
        check_eq("first_start_t3", 32'(fs), 32'd3);

        // Empty matrix: immediate done, nothing sent.
        run_job(0, 4, 0, fs, dc);
        check_eq("n0_done_t1", 32'(dc), 32'd1);
        check_eq("n0_no_start", 32'(fs), 32'd0);

        // Oversize dimension clamps to 4x4.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        run_job(7, 3, 0, fs, dc);
        check_eq("clamp_max_addr", 32'(max_addr), 32'd15);

        // Transmitter held busy before the first byte.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        run_job(1, 5, 50, fs, dc);

        // Ignored second start, then reset mid-word.
        for (int i = 0; i < 16; i++) mem[i] = 32'hA0B0C0D0 + 32'(i) * 32'h01010101;
        build_exp(2);
        rx_q.delete();
        busy_len = 6;
        stab_en  = 1'b0;
        @(negedge clk);
        matrix_size = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rx(2, "rst_seq_byte2");
        matrix_size = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rx(7, "rst_seq_byte7");
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx_start", 32'(tx_start), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_addr", 32'(result_addr), 32'd0);
        check_eq("midrst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++)
            check_eq($sformatf("prefix%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        cyc = 0;
        while (uart_busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        stab_en = 1'b1;
        run_job(2, 6, 0, fs, dc);

        // Randomized jobs.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            run_job(int'($urandom_range(0, 9)), $urandom_range(1, 12), 0, fs, dc);
        end

`ifdef RESULT_SER_CKSUM_EN
        mem[0] = 32'h01020304;
        run_job(1, 3, 0, fs, dc);
        check_eq("cksum_byte", 32'(rx_q[rx_q.size() - 1]), 32'h04);
`endif

        check_eq("no_start_while_busy", 32'(proto_err), 32'd0);
        check_eq("tx_data_stable", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
